mem_bus_arbiter: RTL and testbench

- Shares one external SRAM-style bus (req/ack) between the instruction-fetch port and the MEM-stage data port.
- Sits between the IF/MEM stages and the external memory.
- Drives a registered bus transaction per request and holds the returned data for the requester.
- Raises a stall request to the pipeline controller until each enabled requester has its result.
- Watchdog aborts any transaction that is never acknowledged.

---
 rtl/mem_bus_arbiter_pkg.sv | 14 +
 rtl/mem_bus_arbiter_watchdog.sv | 25 ++
 rtl/mem_bus_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants for the IF/MEM external memory bus arbiter.
// Holds the state encodings, the legacy register-bus constants and the default watchdog length.
package mem_bus_arbiter_pkg;
    localparam int RegBus = 32;
    localparam logic [RegBus-1:0] ZeroWord = '0;
    localparam logic ChipEnable = 1'b1;
    localparam logic WriteEnable = 1'b1;
    localparam int TIMEOUT_DEFAULT = 16;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_DBUS = 2'd1;
    localparam logic [1:0] ARB_IBUS = 2'd2;
    localparam logic [1:0] ARB_TURN = 2'd3;
endpackage

// File: rtl/mem_bus_arbiter_watchdog.sv
// Transaction watchdog: counts cycles while enabled and strobes expire when the count
// reaches TIMEOUT-1, so a bus cycle lasts at most TIMEOUT clocks.
module arb_watchdog
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);
    logic [7:0] count_reg;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + 8'd1;
        end
    end

    assign expire = en && (count_reg == 8'(TIMEOUT - 1));
endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one SRAM-style req/ack bus between instruction fetch and the MEM-stage data port,
// holding each result until the pipeline advances and raising stallreq until results arrive.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int ADDR_W  = RegBus,
    parameter int DATA_W  = RegBus
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall_i,
    input  logic                flush_i,
    input  logic                inst_ce_i,
    input  logic [ADDR_W-1:0]   inst_addr_i,
    output logic [DATA_W-1:0]   inst_data_o,
    input  logic                data_ce_i,
    input  logic                data_we_i,
    input  logic [ADDR_W-1:0]   data_addr_i,
    input  logic [DATA_W/8-1:0] data_sel_i,
    input  logic [DATA_W-1:0]   data_wdata_i,
    output logic [DATA_W-1:0]   data_rdata_o,
    output logic                bus_req_o,
    output logic                bus_we_o,
    output logic [ADDR_W-1:0]   bus_addr_o,
    output logic [DATA_W/8-1:0] bus_sel_o,
    output logic [DATA_W-1:0]   bus_wdata_o,
    input  logic [DATA_W-1:0]   bus_rdata_i,
    input  logic                bus_ack_i,
    output logic                bus_err_o,
    output logic                stallreq_o
);
    logic [1:0] state_reg;
    logic       data_done_reg;
    logic       inst_done_reg;
    logic       drop_reg;
    logic       busy;
    logic       is_data;
    logic       drop_now;
    logic       expire;

    assign busy    = (state_reg == ARB_DBUS) || (state_reg == ARB_IBUS);
    assign is_data = (state_reg == ARB_DBUS);

    // A result is discarded if its requester let go (or fetch was flushed) at any point in flight.
    assign drop_now = drop_reg || (is_data ? (data_ce_i != ChipEnable)
                                           : ((inst_ce_i != ChipEnable) || flush_i));

    assign stallreq_o = (data_ce_i & ~data_done_reg) | (inst_ce_i & ~inst_done_reg);

    arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (!busy),
        .en     (busy),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ARB_IDLE;
            data_done_reg <= 1'b0;
            inst_done_reg <= 1'b0;
            drop_reg      <= 1'b0;
            inst_data_o   <= '0;
            data_rdata_o  <= '0;
            bus_req_o     <= 1'b0;
            bus_we_o      <= 1'b0;
            bus_addr_o    <= '0;
            bus_sel_o     <= '0;
            bus_wdata_o   <= '0;
            bus_err_o     <= 1'b0;
        end else begin
            bus_err_o <= 1'b0;
            if (!stall_i) begin
                data_done_reg <= 1'b0;
                inst_done_reg <= 1'b0;
            end
            if (flush_i) begin
                inst_done_reg <= 1'b0;
            end

            case (state_reg)
                ARB_IDLE: begin
                    drop_reg <= 1'b0;
                    if (data_ce_i == ChipEnable && !data_done_reg) begin
                        state_reg   <= ARB_DBUS;
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= (data_we_i == WriteEnable);
                        bus_addr_o  <= data_addr_i;
                        bus_sel_o   <= data_sel_i;
                        bus_wdata_o <= data_wdata_i;
                    end else if (inst_ce_i == ChipEnable && !inst_done_reg) begin
                        state_reg   <= ARB_IBUS;
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= 1'b0;
                        bus_addr_o  <= inst_addr_i;
                        bus_sel_o   <= '1;
                        bus_wdata_o <= '0;
                    end
                end
                ARB_DBUS, ARB_IBUS: begin
                    drop_reg <= drop_now;
                    if (bus_ack_i || expire) begin
                        state_reg   <= ARB_TURN;
                        bus_req_o   <= 1'b0;
                        bus_we_o    <= 1'b0;
                        bus_addr_o  <= '0;
                        bus_sel_o   <= '0;
                        bus_wdata_o <= '0;
                        // Ack on the expiry edge counts as a normal completion.
                        bus_err_o   <= !bus_ack_i;
                        if (!drop_now) begin
                            if (is_data) begin
                                data_done_reg <= 1'b1;
                                if (!bus_ack_i) begin
                                    data_rdata_o <= '0;
                                end else if (!bus_we_o) begin
                                    data_rdata_o <= bus_rdata_i;
                                end
                            end else begin
                                inst_done_reg <= 1'b1;
                                inst_data_o   <= bus_ack_i ? bus_rdata_i : '0;
                            end
                        end
                    end
                end
                default: begin
                    state_reg <= ARB_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a transaction-level model tracks who owns the bus and
// what each requester should hold; a negedge process compares every output to it each cycle.
module tb_mem_bus_arbiter;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i = 1'b0, flush_i = 1'b0;
    logic        inst_ce_i = 1'b0;
    logic [31:0] inst_addr_i = '0;
    logic [31:0] inst_data_o;
    logic        data_ce_i = 1'b0, data_we_i = 1'b0;
    logic [31:0] data_addr_i = '0;
    logic [3:0]  data_sel_i = '0;
    logic [31:0] data_wdata_i = '0;
    logic [31:0] data_rdata_o;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i = '0;
    logic        bus_ack_i = 1'b0;
    logic        bus_err_o, stallreq_o;

    mem_bus_arbiter #(.TIMEOUT(TO), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
        .inst_ce_i(inst_ce_i), .inst_addr_i(inst_addr_i), .inst_data_o(inst_data_o),
        .data_ce_i(data_ce_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
        .data_sel_i(data_sel_i), .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i),
        .bus_ack_i(bus_ack_i), .bus_err_o(bus_err_o), .stallreq_o(stallreq_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: owner 0 = nobody, 1 = data port, 2 = fetch port; gap = dead cycle after a transfer.
    int          m_owner = 0;
    bit          m_gap = 1'b0;
    int          m_age = 0;
    bit          m_lost = 1'b0;
    bit          m_dd = 1'b0, m_id = 1'b0;
    logic [31:0] m_idata = '0, m_rdata = '0;
    logic        m_req = 1'b0, m_we = 1'b0, m_err = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0;
    logic [3:0]  m_sel = '0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit lost;
        if (!rst_n) begin
            m_owner = 0; m_gap = 0; m_age = 0; m_lost = 0; m_dd = 0; m_id = 0;
            m_idata = '0; m_rdata = '0; m_req = 0; m_we = 0; m_err = 0;
            m_addr = '0; m_wdata = '0; m_sel = '0;
            return;
        end
        m_err = 0;
        begin : advance
            bit dd_now, id_now;
            dd_now = m_dd; id_now = m_id;
            if (!stall_i) begin m_dd = 0; m_id = 0; end
            if (flush_i) m_id = 0;
            if (m_gap) begin
                m_gap = 0;
            end else if (m_owner == 0) begin
                m_lost = 0; m_age = 0;
                if (data_ce_i && !dd_now) begin
                    m_owner = 1; m_req = 1; m_we = data_we_i; m_addr = data_addr_i;
                    m_sel = data_sel_i; m_wdata = data_wdata_i;
                end else if (inst_ce_i && !id_now) begin
                    m_owner = 2; m_req = 1; m_we = 0; m_addr = inst_addr_i;
                    m_sel = 4'hF; m_wdata = '0;
                end
            end else begin
                lost = m_lost || (m_owner == 1 ? !data_ce_i : (!inst_ce_i || flush_i));
                m_lost = lost;
                if (bus_ack_i || m_age == TO - 1) begin
                    m_err = !bus_ack_i;
                    if (!lost) begin
                        if (m_owner == 1) begin
                            m_dd = 1;
                            if (!bus_ack_i) m_rdata = '0;
                            else if (!m_we) m_rdata = bus_rdata_i;
                        end else begin
                            m_id = 1;
                            m_idata = bus_ack_i ? bus_rdata_i : '0;
                        end
                    end
                    m_owner = 0; m_gap = 1; m_req = 0; m_we = 0;
                    m_addr = '0; m_sel = '0; m_wdata = '0;
                end else begin
                    m_age++;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("bus_req_o", {63'd0, bus_req_o}, {63'd0, m_req});
            cmp("bus_we_o", {63'd0, bus_we_o}, {63'd0, m_we});
            cmp("bus_addr_o", {32'd0, bus_addr_o}, {32'd0, m_addr});
            cmp("bus_sel_o", {60'd0, bus_sel_o}, {60'd0, m_sel});
            cmp("bus_wdata_o", {32'd0, bus_wdata_o}, {32'd0, m_wdata});
            cmp("bus_err_o", {63'd0, bus_err_o}, {63'd0, m_err});
            cmp("inst_data_o", {32'd0, inst_data_o}, {32'd0, m_idata});
            cmp("data_rdata_o", {32'd0, data_rdata_o}, {32'd0, m_rdata});
            cmp("stallreq_o", {63'd0, stallreq_o},
                {63'd0, (data_ce_i & ~m_dd) | (inst_ce_i & ~m_id)});
        end
    end

    // One clock: model follows the edge, return just after the following negedge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp(name, {32'd0, act}, {32'd0, exp});
    endtask

    task automatic ack_with(input logic [31:0] rd);
        bus_ack_i = 1'b1; bus_rdata_i = rd;
        tick();
        bus_ack_i = 1'b0; bus_rdata_i = '0;
    endtask

    task automatic cleanup();
        data_ce_i = 0; inst_ce_i = 0; stall_i = 0; flush_i = 0; bus_ack_i = 0; data_we_i = 0;
        repeat (4) tick();
    endtask

    initial begin
        int req_cycles;
        int err_cycles;

        rst_n = 1'b0;
        tick(); tick();
        chk_en = 1'b1;
        rst_n = 1'b1;
        tick();
        $display("reset: bus_req=%0b stallreq=%0b", bus_req_o, stallreq_o);
        lit("reset_bus_req", {31'd0, bus_req_o}, 32'd0);
        lit("reset_rdata", data_rdata_o, 32'd0);

        // Load with single-cycle ack, then hold stall to retire the done flag.
        data_ce_i = 1; data_we_i = 0; data_addr_i = 32'h100; data_sel_i = 4'hF; stall_i = 1;
        tick();
        lit("load_req", {31'd0, bus_req_o}, 32'd1);
        lit("load_addr", bus_addr_o, 32'h100);
        ack_with(32'hDEADBEEF);
        $display("load: rdata=%h stallreq=%0b err=%0b", data_rdata_o, stallreq_o, bus_err_o);
        lit("load_rdata", data_rdata_o, 32'hDEADBEEF);
        lit("load_stallreq", {31'd0, stallreq_o}, 32'd0);
        lit("load_err", {31'd0, bus_err_o}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            lit("retire_no_reissue", {31'd0, bus_req_o}, 32'd0);
        end
        stall_i = 0;
        tick();
        lit("retire_cleared_idle", {31'd0, bus_req_o}, 32'd0);
        stall_i = 1;
        tick();
        $display("retire: reissue bus_req=%0b", bus_req_o);
        lit("retire_reissue", {31'd0, bus_req_o}, 32'd1);
        ack_with(32'h0BADF00D);
        cleanup();

        // Store and fetch together: store first, one dead cycle, then fetch.
        inst_ce_i = 1; inst_addr_i = 32'h0;
        data_ce_i = 1; data_we_i = 1; data_addr_i = 32'h200; data_sel_i = 4'b0011;
        data_wdata_i = 32'h0000ABCD; stall_i = 1;
        tick();
        lit("store_we", {31'd0, bus_we_o}, 32'd1);
        lit("store_addr", bus_addr_o, 32'h200);
        lit("store_sel", {28'd0, bus_sel_o}, 32'h3);
        lit("store_wdata", bus_wdata_o, 32'h0000ABCD);
        ack_with(32'hFFFFFFFF);
        lit("store_turn_req", {31'd0, bus_req_o}, 32'd0);
        lit("store_still_stall", {31'd0, stallreq_o}, 32'd1);
        lit("store_keeps_rdata", data_rdata_o, 32'h0BADF00D);
        tick();
        lit("dead_cycle_req", {31'd0, bus_req_o}, 32'd0);
        tick();
        lit("fetch_req", {31'd0, bus_req_o}, 32'd1);
        lit("fetch_addr", bus_addr_o, 32'h0);
        lit("fetch_sel", {28'd0, bus_sel_o}, 32'hF);
        lit("fetch_we", {31'd0, bus_we_o}, 32'd0);
        ack_with(32'h00000013);
        $display("simul: inst_data=%h stallreq=%0b", inst_data_o, stallreq_o);
        lit("fetch_data", inst_data_o, 32'h13);
        lit("simul_stall_release", {31'd0, stallreq_o}, 32'd0);
        cleanup();

        // Timeout on a load that is never acknowledged.
        data_ce_i = 1; data_we_i = 0; data_addr_i = 32'h300; stall_i = 1;
        req_cycles = 0; err_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus_req_o) req_cycles++;
            if (bus_err_o) err_cycles++;
        end
        $display("timeout: req_cycles=%0d err_cycles=%0d rdata=%h", req_cycles, err_cycles, data_rdata_o);
        lit("timeout_req_cycles", req_cycles, 32'd16);
        lit("timeout_err_pulses", err_cycles, 32'd1);
        lit("timeout_rdata", data_rdata_o, 32'h0);
        lit("timeout_stall_release", {31'd0, stallreq_o}, 32'd0);
        cleanup();

        // Flush during a fetch: result discarded, fresh fetch follows.
        inst_ce_i = 1; inst_addr_i = 32'h40; stall_i = 1;
        tick();
        flush_i = 1;
        tick();
        flush_i = 0;
        ack_with(32'h12345678);
        $display("flush: inst_data=%h stallreq=%0b", inst_data_o, stallreq_o);
        lit("flush_data_kept", inst_data_o, 32'h13);
        lit("flush_not_done", {31'd0, stallreq_o}, 32'd1);
        tick(); tick();
        lit("flush_refetch_req", {31'd0, bus_req_o}, 32'd1);
        lit("flush_refetch_addr", bus_addr_o, 32'h40);
        ack_with(32'h0000CAFE);
        lit("flush_refetch_data", inst_data_o, 32'h0000CAFE);
        cleanup();

        // Reset in the middle of a data transaction; a late ack must be ignored.
        data_ce_i = 1; data_we_i = 0; data_addr_i = 32'h500; stall_i = 1;
        tick();
        lit("rst_mid_req_before", {31'd0, bus_req_o}, 32'd1);
        rst_n = 0;
        tick();
        $display("reset mid: bus_req=%0b addr=%h rdata=%h", bus_req_o, bus_addr_o, data_rdata_o);
        lit("rst_mid_req", {31'd0, bus_req_o}, 32'd0);
        lit("rst_mid_addr", bus_addr_o, 32'h0);
        lit("rst_mid_rdata", data_rdata_o, 32'h0);
        lit("rst_mid_idata", inst_data_o, 32'h0);
        rst_n = 1; data_ce_i = 0;
        ack_with(32'h00000077);
        lit("late_ack_err", {31'd0, bus_err_o}, 32'd0);
        lit("late_ack_rdata", data_rdata_o, 32'h0);
        lit("late_ack_req", {31'd0, bus_req_o}, 32'd0);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
